// File: rtl/ysyx_22050854_pc_bpu.sv
// rtl/ysyx_22050854_pc_bpu.sv - fetch PC register with BTB-based next-PC prediction
// Holds the fetch PC, predicts the next one from a direct-mapped BTB and redirects on mispredict or trap.
module ysyx_22050854_pc_bpu #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h80000000),
  parameter int              BTB_DEPTH = 16,
  parameter int              CNT_BITS  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  input  logic            csr_redirect,
  input  logic [XLEN-1:0] csr_pc,
  output logic            mispredict,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1) << (CNT_BITS - 1);

  logic                btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0]    btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]     btb_target [BTB_DEPTH];
  logic [CNT_BITS-1:0] btb_cnt    [BTB_DEPTH];

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             f_hit, r_hit;
  logic [XLEN-1:0]  next_pc;

  assign f_idx = pc[IDX_W+1:2];
  assign f_tag = pc[XLEN-1:IDX_W+2];
  assign r_idx = res_pc[IDX_W+1:2];
  assign r_tag = res_pc[XLEN-1:IDX_W+2];

  // Lookups read the array before this edge's update lands.
  assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign r_hit       = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
  assign pred_taken  = f_hit && btb_cnt[f_idx][CNT_BITS-1];
  assign pred_target = pred_taken ? btb_target[f_idx] : pc + XLEN'(4);

  assign mispredict = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && res_pred_taken && (res_target != res_pred_target)));

  always_comb begin
    next_pc = pred_target;
    if (csr_redirect)    next_pc = csr_pc;
    else if (mispredict) next_pc = res_taken ? res_target : res_pc + XLEN'(4);
    else if (stall)      next_pc = pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_PC;
      mispredict_cnt <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) btb_valid[i] <= 1'b0;
    end else begin
      pc <= next_pc;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
      if (res_valid) begin
        if (r_hit) begin
          if (res_taken) begin
            btb_target[r_idx] <= res_target;
            if (btb_cnt[r_idx] != CNT_MAX) btb_cnt[r_idx] <= btb_cnt[r_idx] + CNT_BITS'(1);
          end else if (btb_cnt[r_idx] != '0) begin
            btb_cnt[r_idx] <= btb_cnt[r_idx] - CNT_BITS'(1);
          end
        end else if (res_taken) begin
          btb_valid[r_idx]  <= 1'b1;
          btb_tag[r_idx]    <= r_tag;
          btb_target[r_idx] <= res_target;
          btb_cnt[r_idx]    <= CNT_INIT;
        end
      end
    end
  end

endmodule

// File: doc/ysyx_22050854_pc_bpu.md
Name: ysyx_22050854_pc_bpu

Overview:
Parametrised next-generation fetch PC unit with dynamic branch prediction. Holds the architectural fetch PC and predicts next fetch address each cycle from a direct-mapped BTB carrying per-entry saturating counters. Consumes branch-resolution results from the execute stage, detects mispredictions and redirects. Trap/return (CSR) redirects take highest priority. Sits between IF and ID/EX, replacing the fixed pc+4/compute-at-decode scheme.

Parameters:
XLEN, 32, PC and target width in bits
RESET_PC, 32'h80000000, PC value loaded on reset
BTB_DEPTH, 16, BTB entries; power of two, >= 2
CNT_BITS, 2, saturating counter width; predict taken when counter MSB = 1

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
stall  in  1  hold PC (data conflict / memory suspend)
pc  out  XLEN  current fetch PC (registered)
pred_taken  out  1  prediction for pc: BTB hit and counter MSB set
pred_target  out  XLEN  predicted next PC (target if pred_taken, else pc+4)
res_valid  in  1  one control-transfer instruction resolved this cycle
res_pc  in  XLEN  PC of resolved instruction
res_taken  in  1  actual direction (jal/jalr always 1)
res_target  in  XLEN  actual taken target
res_pred_taken  in  1  pred_taken carried down pipeline with the instruction
res_pred_target  in  XLEN  pred_target carried down pipeline
csr_redirect  in  1  ecall/mret redirect valid
csr_pc  in  XLEN  trap/return target
mispredict  out  1  combinational: flush younger stages
mispredict_cnt  out  32  number of mispredictions since reset

Behaviour:
- Reset (sync, active-high): pc = RESET_PC; all BTB valid bits = 0; mispredict_cnt = 0. Outputs pred_taken = 0, pred_target = RESET_PC+4 during/after reset until first BTB allocation.
- Index = pc[log2(BTB_DEPTH)+1:2]; tag = pc[XLEN-1:log2(BTB_DEPTH)+2]; pc[1:0] ignored.
- Lookup combinational on pc, zero latency: hit = valid & tag match. pred_taken = hit & cnt[CNT_BITS-1]; pred_target = pred_taken ? entry.target : pc+4 (modulo 2^XLEN, wraps).
- mispredict = res_valid & ((res_taken != res_pred_taken) | (res_taken & res_pred_taken & res_target != res_pred_target)).
- Next-PC priority at each posedge (not reset): 1) csr_redirect: pc <= csr_pc; 2) mispredict: pc <= res_taken ? res_target : res_pc+4; 3) stall: pc holds; 4) else pc <= pred_target. Redirects override stall; csr_redirect overrides mispredict in same cycle.
- BTB update on res_valid (independent of stall and csr_redirect), at the posedge:
  - hit on res_pc: counter +1 if res_taken (saturate at 2^CNT_BITS-1), -1 if not (saturate at 0); if res_taken, target <= res_target.
  - miss and res_taken: allocate/overwrite entry: valid=1, tag, target=res_target, counter = 2^(CNT_BITS-1) (weakly taken).
  - miss and not taken: no change.
- Same-cycle read/write of same index: lookup returns pre-update contents; new data visible next cycle.
- mispredict_cnt increments by 1 per mispredict cycle, wraps at 2^32.
- Single resolution port; at most one update per cycle. No reset-mid-operation state beyond above: reset asserted any cycle wins over all redirects and updates.

Test Plan:
- Reset asserted 2 cycles then released, no stall, no res_valid -> pc = 0x80000000, 0x80000004, 0x80000008...; pred_taken = 0; mispredict_cnt = 0.
- res_valid, res_pc=0x80000010, res_taken=1, res_target=0x80000100, res_pred_taken=0 -> mispredict=1, next pc=0x80000100, mispredict_cnt=1; later fetch at 0x80000010 -> pred_taken=1, pred_target=0x80000100.
- Two not-taken resolutions of 0x80000010 (res_pred_taken matching each) -> counter 2->1->0, first one mispredicts (pred 1), second does not; fetch 0x80000010 then pred_taken=0, pred_target=0x80000014.
- Four taken resolutions of a hit entry -> counter saturates at 3, no wrap to 0; prediction stays taken.
- stall=1 held 3 cycles with csr_redirect pulsed (csr_pc=0x80000200) in cycle 2 -> pc holds, then 0x80000200 despite stall; same cycle mispredict also asserted -> csr_pc wins, BTB still updated.
- Aliasing: allocate 0x80000010, then fetch 0x80000050 (same index with DEPTH=16, different tag) -> pred_taken=0, pred_target=0x80000054.
